dac_spi_responder: RTL and testbench

- SPI responder (slave) modelling the 16-bit DAC on the DAC_CS_n / DAC_clk / DAC_data link, i.e. the receiving end of the DAC SPI master.
- Oversamples the SPI pins on the system clock, deframes one DAC word per chip-select window and presents it with a one-cycle strobe.
- Used in the DPLL bench as the DAC model and checker, and on hardware as a loopback monitor of DAC_val feeding the UART register map.

---
 rtl/dac_spi_responder_if.sv | 29 ++
 rtl/dac_spi_responder.sv | 211 +++++++++++++++++++++
 tb/tb_dac_spi_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_responder_if.sv
// DAC SPI link plus the deframed-word status bundle seen by the DAC model.
interface dac_spi_responder_if #(
   parameter int unsigned WORD_BITS = 16
);
   logic                 i_SPI_Clk;
   logic                 i_SPI_MOSI;
   logic                 i_SPI_CS_n;
   logic                 o_SPI_MISO;
   logic [WORD_BITS-1:0] o_Word;
   logic                 o_Word_DV;
   logic                 o_Frame_Err;
   logic                 o_Busy;
   logic [15:0]          o_Frame_Count;
   logic [7:0]           o_Err_Count;

   // SPI master side (drives the pins, observes the responder status)
   modport master (
      output i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
      input  o_SPI_MISO, o_Word, o_Word_DV, o_Frame_Err, o_Busy,
             o_Frame_Count, o_Err_Count
   );

   // Responder side
   modport slave (
      input  i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
      output o_SPI_MISO, o_Word, o_Word_DV, o_Frame_Err, o_Busy,
             o_Frame_Count, o_Err_Count
   );
endinterface

// File: rtl/dac_spi_responder.sv
// SPI mode-0 responder modelling the 16-bit DAC: oversamples the SPI pins,
// deframes one word per CS_n window and strobes it out.
// Optional readback of the previous word on MISO: define DAC_SPI_READBACK_EN.
module dac_spi_responder #(
   parameter int unsigned WORD_BITS   = 16,
   parameter int unsigned SYNC_STAGES = 2    // legal 2..3
) (
   input logic                 i_Clk,
   input logic                 i_Rst_L,
   dac_spi_responder_if.slave  bus
);

   localparam int unsigned CNT_W   = $clog2(WORD_BITS + 1);
   localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(WORD_BITS);
   localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
   logic                   cs_hist, sclk_hist;
   logic                   cs_last, sclk_last;
   logic                   cs_fall_c, cs_rise_c, sclk_rise_c;
   logic                   cs_fall_q, cs_rise_q, sclk_rise_q, mosi_q;

   logic [FLUSH_W-1:0]     flush_cnt;
   logic                   armed;

   logic [1:0]             state, state_d;
   logic [WORD_BITS-1:0]   shift_sr, shift_sr_d;
   logic [CNT_W-1:0]       bit_cnt, bit_cnt_d;
   logic                   commit_ok, commit_ok_d;
   logic                   commit_err, commit_err_d;

   logic [WORD_BITS-1:0]   word_q;
   logic                   word_dv_q, frame_err_q, busy_q;
   logic [15:0]            frame_cnt_q;
   logic [7:0]             err_cnt_q;

   assign cs_last     = cs_sync[SYNC_STAGES-1];
   assign sclk_last   = sclk_sync[SYNC_STAGES-1];
   assign cs_fall_c   = cs_hist & ~cs_last;
   assign cs_rise_c   = ~cs_hist & cs_last;
   assign sclk_rise_c = ~sclk_hist & sclk_last;

   // Synchronisers, history flops and registered edge/data pulses
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cs_sync     <= '1;
         sclk_sync   <= '0;
         mosi_sync   <= '0;
         cs_hist     <= 1'b1;
         sclk_hist   <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
         sclk_rise_q <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         cs_sync     <= {cs_sync[SYNC_STAGES-2:0],   bus.i_SPI_CS_n};
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], bus.i_SPI_Clk};
         mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
         cs_hist     <= cs_last;
         sclk_hist   <= sclk_last;
         cs_fall_q   <= cs_fall_c;
         cs_rise_q   <= cs_rise_c;
         sclk_rise_q <= sclk_rise_c;
         mosi_q      <= mosi_sync[SYNC_STAGES-1];
      end
   end

   // Arm only once the sync chain has flushed and CS_n is seen high, so a
   // CS_n already low at reset release cannot start a frame
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         flush_cnt <= '0;
         armed     <= 1'b0;
      end else if (flush_cnt != FLUSH_DONE) begin
         flush_cnt <= flush_cnt + FLUSH_W'(1);
      end else if (cs_hist) begin
         armed <= 1'b1;
      end
   end

   // Frame state register and datapath
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state      <= ST_IDLE;
         shift_sr   <= '0;
         bit_cnt    <= '0;
         commit_ok  <= 1'b0;
         commit_err <= 1'b0;
      end else begin
         state      <= state_d;
         shift_sr   <= shift_sr_d;
         bit_cnt    <= bit_cnt_d;
         commit_ok  <= commit_ok_d;
         commit_err <= commit_err_d;
      end
   end

   // Next-state logic; cs_rise takes priority over a same-cycle sclk_rise
   always_comb begin
      state_d      = state;
      shift_sr_d   = shift_sr;
      bit_cnt_d    = bit_cnt;
      commit_ok_d  = 1'b0;
      commit_err_d = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cs_fall_q && armed) begin
               shift_sr_d = '0;
               bit_cnt_d  = '0;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cs_rise_q) begin
               commit_err_d = 1'b1;
               state_d      = ST_IDLE;
            end else if (sclk_rise_q) begin
               shift_sr_d = {shift_sr[WORD_BITS-2:0], mosi_q};
               bit_cnt_d  = bit_cnt + CNT_W'(1);
               if (bit_cnt_d == CNT_FULL) begin
                  state_d = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            if (cs_rise_q) begin
               commit_ok_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (sclk_rise_q) begin
               state_d = ST_ERR;
            end
         end
         default: begin
            if (cs_rise_q) begin
               commit_err_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
      endcase
   end

   // Registered outputs: word, strobes, counters, busy
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         word_q      <= '0;
         word_dv_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         word_dv_q   <= commit_ok;
         frame_err_q <= commit_err;
         busy_q      <= (state != ST_IDLE);
         if (commit_ok) begin
            word_q      <= shift_sr;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (commit_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign bus.o_Word        = word_q;
   assign bus.o_Word_DV     = word_dv_q;
   assign bus.o_Frame_Err   = frame_err_q;
   assign bus.o_Busy        = busy_q;
   assign bus.o_Frame_Count = frame_cnt_q;
   assign bus.o_Err_Count   = err_cnt_q;

`ifdef DAC_SPI_READBACK_EN
   logic [WORD_BITS-1:0] rb_sr;
   logic                 rb_active;
   logic                 miso_q;
   logic                 sclk_fall_c;

   assign sclk_fall_c = sclk_hist & ~sclk_last;

   // Readback: load last word at frame start, shift out on each SCLK fall;
   // driven from the unregistered edges to leave setup margin for the master
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         rb_sr     <= '0;
         rb_active <= 1'b0;
         miso_q    <= 1'b0;
      end else if (cs_rise_c) begin
         rb_active <= 1'b0;
         miso_q    <= 1'b0;
      end else if (cs_fall_c && armed && (state == ST_IDLE)) begin
         rb_sr     <= word_q;
         rb_active <= 1'b1;
         miso_q    <= word_q[WORD_BITS-1];
      end else if (rb_active && sclk_fall_c) begin
         rb_sr  <= {rb_sr[WORD_BITS-2:0], 1'b0};
         miso_q <= rb_sr[WORD_BITS-2];
      end
   end

   assign bus.o_SPI_MISO = miso_q;
`else
   assign bus.o_SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_responder.sv
// Bench for dac_spi_responder: directed frames plus random frames checked
// against a frame-level reference model (word / counters / strobe totals).
module tb_dac_spi_responder;

   localparam int unsigned WORD_BITS   = 16;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned HALF        = 4;   // SCLK = i_Clk/8

   logic i_Clk;
   logic i_Rst_L;

   dac_spi_responder_if #(.WORD_BITS(WORD_BITS)) bus ();

   dac_spi_responder #(
      .WORD_BITS   (WORD_BITS),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .bus     (bus)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [15:0] exp_word = '0;
   int          exp_fc   = 0;
   int          exp_ec   = 0;
   int          exp_dv   = 0;
   int          exp_err  = 0;

   // Strobe monitor
   int   dv_pulses   = 0;
   int   err_pulses  = 0;
   int   wide_pulses = 0;
   logic dv_prev     = 1'b0;
   logic err_prev    = 1'b0;

   always @(negedge i_Clk) begin
      if (bus.o_Word_DV)   dv_pulses++;
      if (bus.o_Frame_Err) err_pulses++;
      if ((bus.o_Word_DV && dv_prev) || (bus.o_Frame_Err && err_prev)) wide_pulses++;
      dv_prev  = bus.o_Word_DV;
      err_prev = bus.o_Frame_Err;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge i_Clk);
   endtask

   // Clock out nbits of data MSB first; capture MISO just before each rise
   task automatic send_bits(input logic [31:0] data, input int nbits,
                            input int gap_after, input int gap_len,
                            output logic [15:0] rb);
      rb = '0;
      for (int i = 0; i < nbits; i++) begin
         bus.i_SPI_MOSI = data[nbits-1-i];
         wait_cyc(HALF);
         if (i < 16) rb = {rb[14:0], bus.o_SPI_MISO};
         bus.i_SPI_Clk = 1'b1;
         wait_cyc(HALF);
         bus.i_SPI_Clk = 1'b0;
         if (i == gap_after) wait_cyc(gap_len);
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_word"},    32'(bus.o_Word),        32'(exp_word));
      chk({tag, "_fcount"},  32'(bus.o_Frame_Count), 32'(exp_fc));
      chk({tag, "_ecount"},  32'(bus.o_Err_Count),   32'(exp_ec));
      chk({tag, "_dv_tot"},  32'(dv_pulses),         32'(exp_dv));
      chk({tag, "_err_tot"}, 32'(err_pulses),        32'(exp_err));
      chk({tag, "_idle"},    32'(bus.o_Busy),        32'd0);
      chk({tag, "_miso_idle"}, 32'(bus.o_SPI_MISO),  32'd0);
   endtask

   // One complete CS window followed by model update and checks
   task automatic run_frame(input string tag, input logic [31:0] data, input int nbits,
                            input int gap_after, input int gap_len);
      logic [15:0] rb;
      logic [15:0] exp_rb;
      int          k;
      logic        seen;
`ifdef DAC_SPI_READBACK_EN
      exp_rb = exp_word;
`else
      exp_rb = '0;
`endif
      bus.i_SPI_CS_n = 1'b0;
      wait_cyc(6);
      send_bits(data, nbits, gap_after, gap_len, rb);
      wait_cyc(6);
      chk({tag, "_busy"}, 32'(bus.o_Busy), 32'd1);
      bus.i_SPI_CS_n = 1'b1;
      if (nbits == int'(WORD_BITS)) begin
         exp_word = data[15:0];
         exp_fc   = (exp_fc + 1) % 65536;
         exp_dv++;
      end else begin
         if (exp_ec < 255) exp_ec++;
         exp_err++;
      end
      if (nbits >= int'(WORD_BITS)) chk({tag, "_readback"}, 32'(rb), 32'(exp_rb));
      // First edge that samples CS_n high, then count edges to the strobe
      @(posedge i_Clk);
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         @(posedge i_Clk);
         #1;
         k++;
         seen = bus.o_Word_DV | bus.o_Frame_Err;
      end
      chk({tag, "_latency"}, 32'(k), 32'(SYNC_STAGES + 2));
      wait_cyc(4);
      check_status(tag);
   endtask

   logic [15:0] rb_dummy;

   initial begin
      i_Rst_L        = 1'b0;
      bus.i_SPI_CS_n = 1'b1;
      bus.i_SPI_Clk  = 1'b0;
      bus.i_SPI_MOSI = 1'b0;
      wait_cyc(3);
      check_status("reset");
      chk("reset_dv",  32'(bus.o_Word_DV),   32'd0);
      chk("reset_err", 32'(bus.o_Frame_Err), 32'd0);
      i_Rst_L = 1'b1;
      wait_cyc(10);

      // Clean frame, then same word split by a long SCLK pause
      run_frame("clean", 32'h9E23, 16, -1, 0);
      run_frame("split", 32'h9E23, 16, 7, 550);
      // Short frame, overrun, recovery
      run_frame("short", 32'hABC, 12, -1, 0);
      run_frame("overrun", 32'h1_5A5A, 17, -1, 0);
      run_frame("recover", 32'h1234, 16, -1, 0);
      // CS_n glitch with no SCLK
      run_frame("glitch", 32'h0, 0, -1, 0);
      // Readback pair: second frame reads back the first word
      run_frame("rb_first", 32'h9E23, 16, -1, 0);
      run_frame("rb_second", 32'h0000, 16, -1, 0);

      // Reset in the middle of a frame, released with CS_n still low
      bus.i_SPI_CS_n = 1'b0;
      wait_cyc(6);
      send_bits(32'hA5, 8, -1, 0, rb_dummy);
      i_Rst_L = 1'b0;
      #1;
      exp_word = '0;
      exp_fc   = 0;
      exp_ec   = 0;
      check_status("midrst");
      wait_cyc(3);
      i_Rst_L = 1'b1;
      wait_cyc(10);
      bus.i_SPI_CS_n = 1'b1;
      wait_cyc(20);
      chk("midrst_no_dv",  32'(dv_pulses),  32'(exp_dv));
      chk("midrst_no_err", 32'(err_pulses), 32'(exp_err));
      chk("midrst_word",   32'(bus.o_Word), 32'd0);
      run_frame("post_rst", 32'h00FF, 16, -1, 0);

      // Random frames: mostly clean, some short, some overrun, some paused
      for (int f = 0; f < 40; f++) begin
         int          sel, nb, ga, gl;
         logic [31:0] d;
         sel = int'($urandom_range(0, 9));
         if (sel < 6)      nb = 16;
         else if (sel < 8) nb = int'($urandom_range(0, 15));
         else              nb = int'($urandom_range(17, 19));
         d  = $urandom;
         ga = -1;
         gl = 0;
         if (nb > 0 && $urandom_range(0, 3) == 0) begin
            ga = int'($urandom_range(0, nb - 1));
            gl = int'($urandom_range(10, 60));
         end
         run_frame("rand", d, nb, ga, gl);
      end

      // Error counter saturation
      while (exp_err < 300 && !(exp_ec == 255 && bus.o_Err_Count == 8'hFF && exp_err > 270))
         run_frame("sat", 32'h0, 0, -1, 0);
      chk("sat_ecount", 32'(bus.o_Err_Count), 32'hFF);

      chk("strobe_width", 32'(wide_pulses), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
